// File: rtl/dram_ctrl_pkg.sv
// Shared encodings and helpers for the DRAM arbiter / access sequencer.
package dram_ctrl_pkg;

    // Access size encodings on req_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RDATA  = 2'b10,
        RESP   = 2'b11
    } state_t;

    // A request is rejected for an illegal size, a misaligned half/word, or an
    // address outside the DRAM window starting at base.
    function automatic logic req_error(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned addr_w);
        logic misalign;
        logic out_of_range;
        misalign     = (size == SIZE_X) ||
                       ((size == SIZE_H) && addr[0]) ||
                       ((size == SIZE_W) && (addr[1:0] != 2'b00));
        out_of_range = ((addr ^ base) >> (addr_w + 2)) != 32'd0;
        return misalign || out_of_range;
    endfunction

endpackage

// File: rtl/dram_lane_fmt.sv
// Byte-lane formatting between byte-addressed requests and 32-bit DRAM words.
// Store side builds lane enables and replicated data; load side extracts and
// extends the addressed byte/half.
module dram_lane_fmt
    import dram_ctrl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_rdata
);

    logic [31:0]        ld_shifted;
    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;
    logic signed [31:0] ld_byte_ext;
    logic signed [31:0] ld_half_ext;

    // Store lane enables and replication of the right-justified store data
    always_comb begin
        st_be   = 4'b1111;
        st_data = st_wdata;
        case (st_size)
            SIZE_B: begin
                st_be   = 4'b0001 << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            SIZE_H: begin
                st_be   = 4'b0011 << st_off;
                st_data = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = st_wdata;
            end
        endcase
    end

    // Load extraction: shift addressed lane down, then sign/zero extend
    always_comb begin
        ld_shifted  = ld_raw >> {ld_off, 3'b000};
        ld_byte     = $signed(ld_shifted[7:0]);
        ld_half     = $signed(ld_shifted[15:0]);
        ld_byte_ext = ld_byte;
        ld_half_ext = ld_half;
        case (ld_size)
            SIZE_B:  ld_rdata = ld_unsigned ? {24'd0, ld_shifted[7:0]} : ld_byte_ext;
            SIZE_H:  ld_rdata = ld_unsigned ? {16'd0, ld_shifted[15:0]} : ld_half_ext;
            default: ld_rdata = ld_raw;
        endcase
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the single-port
// DRAM (registered read, byte-enabled write).
module dram_arbiter
    import dram_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [3:0]        req_size,
    input  logic [1:0]        req_unsigned,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [3:0]        mem_wr_byte_en,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data
);

    state_t      state;
    logic        last_grant;
    logic        owner_q;
    logic        err_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;

    logic        gnt_id;
    logic        gnt_any;
    logic        accept;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_rdata;

    // Round-robin pick: a lone requester wins, a tie goes against last_grant
    always_comb begin
        gnt_any   = |req_valid;
        gnt_id    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        accept    = (state == IDLE) && gnt_any;
        req_ready = accept ? (2'b01 << gnt_id) : 2'b00;
        sel_we    = gnt_id ? req_we[1]        : req_we[0];
        sel_size  = gnt_id ? req_size[3:2]    : req_size[1:0];
        sel_uns   = gnt_id ? req_unsigned[1]  : req_unsigned[0];
        sel_addr  = gnt_id ? req_addr[63:32]  : req_addr[31:0];
        sel_wdata = gnt_id ? req_wdata[63:32] : req_wdata[31:0];
        sel_err   = req_error(sel_size, sel_addr, BASE_ADDR, ADDR_W);
    end

    dram_lane_fmt u_fmt (
        .st_size     (sel_size),
        .st_off      (sel_addr[1:0]),
        .st_wdata    (sel_wdata),
        .st_be       (st_be),
        .st_data     (st_data),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_raw      (mem_rd_data),
        .ld_rdata    (ld_rdata)
    );

    // Request attributes captured on accept; only read in later states
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q   <= sel_we;
            size_q <= sel_size;
            off_q  <= sel_addr[1:0];
            uns_q  <= sel_uns;
        end
    end

    // Sequencer FSM driving the DRAM port and the response pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner_q        <= 1'b0;
            err_q          <= 1'b0;
            rsp_valid      <= 2'b00;
            rsp_err        <= 1'b0;
            rsp_rdata      <= 32'd0;
            mem_addr       <= '0;
            mem_wr_en      <= 1'b0;
            mem_wr_byte_en <= 4'b0000;
            mem_wr_data    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= gnt_id;
                        owner_q    <= gnt_id;
                        err_q      <= sel_err;
                        state      <= ACCESS;
                        if (!sel_err) begin
                            mem_addr       <= sel_addr[ADDR_W+1:2];
                            mem_wr_en      <= sel_we;
                            mem_wr_byte_en <= sel_we ? st_be : 4'b0000;
                            mem_wr_data    <= st_data;
                        end
                    end
                end
                ACCESS: begin
                    mem_wr_en <= 1'b0;
                    if (!we_q && !err_q) begin
                        state <= RDATA;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 2'b01 << owner_q;
                        rsp_err   <= err_q;
                        rsp_rdata <= 32'd0;
                    end
                end
                RDATA: begin
                    state     <= RESP;
                    rsp_valid <= 2'b01 << owner_q;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ld_rdata;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                end
            endcase
        end
    end

endmodule
